cluster_speriph_plug_arbiter: RTL

// - Round-robin arbiter sharing one peripheral slave port (event unit speriph port) among NB_PLUGS speriph plugs.
// - Replaces priority muxing of plugs: one plug granted per cycle, no request dropped on collision.
// - Tracks outstanding transactions in an in-order FIFO; routes each response (r_valid/r_rdata/r_opc/r_id) to its originating plug.

---
 rtl/cluster_speriph_plug_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/cluster_speriph_plug_arbiter.sv
// Round-robin arbiter sharing one speriph slave port among NB_PLUGS plugs, with an in-order response router.
// Optional statistics counters are enabled with the macro SPERIPH_ARB_STATS_EN.
module cluster_speriph_plug_arbiter #(
    parameter int unsigned NB_PLUGS  = 2,
    parameter int unsigned ID_WIDTH  = 5,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NB_PLUGS-1:0]                plug_req_i,
    input  logic [NB_PLUGS-1:0][31:0]          plug_add_i,
    input  logic [NB_PLUGS-1:0]                plug_wen_i,
    input  logic [NB_PLUGS-1:0][31:0]          plug_wdata_i,
    input  logic [NB_PLUGS-1:0][3:0]           plug_be_i,
    input  logic [NB_PLUGS-1:0][ID_WIDTH-1:0]  plug_id_i,
    output logic [NB_PLUGS-1:0]                plug_gnt_o,
    output logic [NB_PLUGS-1:0]                plug_r_valid_o,
    output logic [31:0]                        plug_r_rdata_o,
    output logic                               plug_r_opc_o,
    output logic [ID_WIDTH-1:0]                plug_r_id_o,
    output logic                               slv_req_o,
    output logic [31:0]                        slv_add_o,
    output logic                               slv_wen_o,
    output logic [31:0]                        slv_wdata_o,
    output logic [3:0]                         slv_be_o,
    output logic [ID_WIDTH-1:0]                slv_id_o,
    input  logic                               slv_gnt_i,
    input  logic                               slv_r_valid_i,
    input  logic [31:0]                        slv_r_rdata_i,
    input  logic                               slv_r_opc_i,
    input  logic [ID_WIDTH-1:0]                slv_r_id_i,
    output logic                               unexp_rsp_o
`ifdef SPERIPH_ARB_STATS_EN
    ,
    output logic [NB_PLUGS-1:0][15:0]          stat_grant_o,
    output logic [15:0]                        stat_confl_o,
    output logic [15:0]                        stat_full_o
`endif
);

    localparam int unsigned SEL_W = (NB_PLUGS > 1) ? $clog2(NB_PLUGS) : 1;
    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;

    logic [SEL_W-1:0] rr_q, rr_d;
    logic [SEL_W-1:0] sel_rr, sel;
    logic             lock_q, lock_d;
    logic [SEL_W-1:0] lock_sel_q;
    logic             any_req, accept, pop;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [SEL_W-1:0] fifo_q [MAX_OUTST];
    logic [SEL_W-1:0] head;
    logic             unexp_q;

    // Cyclic search for the first requester at or after the round-robin pointer.
    always_comb begin
        int  idx;
        logic found;
        found  = 1'b0;
        sel_rr = '0;
        for (int i = 0; i < int'(NB_PLUGS); i++) begin
            idx = int'(rr_q) + i;
            if (idx >= int'(NB_PLUGS)) idx = idx - int'(NB_PLUGS);
            if (!found && plug_req_i[idx]) begin
                found  = 1'b1;
                sel_rr = SEL_W'(idx);
            end
        end
    end

    // A stalled request keeps its plug even if an earlier-priority plug starts requesting.
    assign sel        = lock_q ? lock_sel_q : sel_rr;
    assign any_req    = |plug_req_i;
    assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTST));
    assign fifo_empty = (cnt_q == '0);
    assign slv_req_o  = rst_ni & any_req & ~fifo_full;
    assign accept     = slv_req_o & slv_gnt_i;
    assign pop        = rst_ni & slv_r_valid_i & ~fifo_empty;
    assign head       = fifo_q[rd_ptr_q];
    assign lock_d     = slv_req_o & ~slv_gnt_i;

    always_comb begin
        slv_add_o   = '0;
        slv_wen_o   = 1'b0;
        slv_wdata_o = '0;
        slv_be_o    = '0;
        slv_id_o    = '0;
        if (any_req) begin
            slv_add_o   = plug_add_i[sel];
            slv_wen_o   = plug_wen_i[sel];
            slv_wdata_o = plug_wdata_i[sel];
            slv_be_o    = plug_be_i[sel];
            slv_id_o    = plug_id_i[sel];
        end
    end

    always_comb begin
        plug_gnt_o     = '0;
        plug_r_valid_o = '0;
        for (int i = 0; i < int'(NB_PLUGS); i++) begin
            plug_gnt_o[i]     = accept && (sel == SEL_W'(i));
            plug_r_valid_o[i] = pop && (head == SEL_W'(i));
        end
    end

    assign plug_r_rdata_o = slv_r_rdata_i;
    assign plug_r_opc_o   = slv_r_opc_i;
    assign plug_r_id_o    = slv_r_id_i;
    assign unexp_rsp_o    = unexp_q;

    always_comb begin
        rr_d = rr_q;
        if (accept) rr_d = (sel == SEL_W'(NB_PLUGS - 1)) ? '0 : sel + SEL_W'(1);
        cnt_d = cnt_q;
        if (accept && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!accept && pop) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_sel_q <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            unexp_q    <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_sel_q <= sel;
            cnt_q      <= cnt_d;
            if (accept) begin
                fifo_q[wr_ptr_q] <= sel;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            if (slv_r_valid_i && fifo_empty) unexp_q <= 1'b1;
        end
    end

`ifdef SPERIPH_ARB_STATS_EN
    logic [NB_PLUGS-1:0][15:0] stat_grant_q;
    logic [15:0]               stat_confl_q, stat_full_q;
    logic                      confl, full_blk;

    assign confl    = ($countones(plug_req_i) >= 2) && slv_req_o;
    assign full_blk = rst_ni & any_req & fifo_full;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stat_grant_q <= '0;
            stat_confl_q <= '0;
            stat_full_q  <= '0;
        end else begin
            for (int i = 0; i < int'(NB_PLUGS); i++) begin
                if (plug_gnt_o[i] && stat_grant_q[i] != 16'hFFFF)
                    stat_grant_q[i] <= stat_grant_q[i] + 16'd1;
            end
            if (confl && stat_confl_q != 16'hFFFF) stat_confl_q <= stat_confl_q + 16'd1;
            if (full_blk && stat_full_q != 16'hFFFF) stat_full_q <= stat_full_q + 16'd1;
        end
    end

    assign stat_grant_o = stat_grant_q;
    assign stat_confl_o = stat_confl_q;
    assign stat_full_o  = stat_full_q;
`endif

endmodule
